systolic_skew_feeder: RTL and testbench
=======================================

# systolic_skew_feeder

Parametrised activation skew feeder for an N×N systolic array. It accepts a full N×N activation tile over a valid/ready handshake and emits it as 2N−1 diagonal "waves". Each wave is one N-lane vector, with lane i delayed by i cycles and zero-padded. The block sits between the activation buffer and the row inputs of the systolic array. It generalises the fixed 2×2 setup stage to any N and data width, and adds output back-pressure and optional back-to-back tile streaming.

## Interface
- N, 4, array dimension (rows = lanes = tile columns); N ≥ 2
- DW, 8, activation width in bits
- clk  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  tile present on in_tile
- in_ready  output  1  feeder can accept a tile this cycle
- in_tile  input  N*N*DW  row-major tile; element A[r][c] at bits [(r*N+c)*DW +: DW]
- out_valid  output  1  out_data holds a valid wave
- out_ready  input  1  array consumes the wave this cycle
- out_data  output  N*DW  lane i at bits [i*DW +: DW]
- out_first  output  1  current wave is wave 0 of a tile
- out_last  output  1  current wave is wave 2N−2 of a tile

## Operation
- States: IDLE and STREAM.
- Reset values: state IDLE, wave counter 0, out_valid 0, out_data 0, out_first 0, out_last 0, buffers 0. in_ready is 1 while reset is held and in IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, capture in_tile into the active buffer, set wave counter w = 0, and go to STREAM.
- STREAM:
  - out_valid = 1.
  - Lane i of wave w = A[i][w−i] when 0 ≤ w−i ≤ N−1, else 0.
  - out_first = (w == 0); out_last = (w == 2N−2).
- Wave advance happens only on out_valid && out_ready. While out_ready is low, out_data, out_first and out_last hold stable.
- After the last wave (w = 2N−2) is consumed:
  - With a next tile pending, load it and restart at w = 0 (see Configuration).
  - Otherwise, return to IDLE with out_valid = 0 and out_data = 0.
- Counter width is $clog2(2N−1), minimum 1. The counter never exceeds 2N−2.
- No arithmetic is performed on data. Data passes through bit-exact; padding is all-zeros.
- Reset mid-stream: abort immediately, discard both buffers, and emit no partial wave after reset deasserts.

## Timing
- Tile handshake at clock edge k → wave 0 is on out_data with out_valid = 1 in the cycle after edge k. Latency is 1 cycle.
- All outputs are registered except in_ready, which is combinational from state and buffer occupancy only, never from in_valid.
- With out_ready tied to 1, one tile occupies exactly 2N−1 consecutive out_valid cycles.
- in_valid with in_ready low: no capture. The source must hold in_tile until the handshake completes.

## Configuration
- SKEW_FEEDER_DBUF_EN defined: adds a shadow tile buffer.
  - In STREAM, in_ready = !shadow_full.
  - A tile accepted in STREAM goes to the shadow buffer.
  - When the last wave is consumed and the shadow buffer is full, the shadow moves to active and wave 0 of the next tile appears on the next cycle, with no bubble.
  - If the shadow buffer is empty but in_valid is high in the same cycle the last wave is consumed, the tile loads directly into active, again with no bubble.
- Not defined:
  - in_ready = 1 only in IDLE.
  - After the last wave is consumed the block always returns to IDLE, so there is at least one idle cycle (out_valid = 0) between tiles.

## Structure
- Package systolic_pkg holds:
  - the state_t typedef {IDLE, STREAM};
  - a localparam function for the wave count 2N−1.
- One sub-module, skew_lane_mux (parameters N, DW, lane index L). It takes one tile row and w, and produces that lane's element or zero. It is instantiated N times by generate.
- Top level holds the FSM, counter, buffers and handshakes.

## Test plan
- Basic, N=2, DW=8: tile [[1,2],[3,4]], out_ready=1 → lane0 = 1,2,0; lane1 = 0,3,4; out_first on cycle 1, out_last on cycle 3; then out_valid = 0.
- Back-pressure, N=4: out_ready deasserted for 3 cycles at w=2 → out_data/out_last frozen; full 7-wave sequence intact.
- Back-to-back with SKEW_FEEDER_DBUF_EN, N=2: tile B presented during A's wave 1 → B's wave 0 immediately follows A's wave 2; zero idle cycles.
- Back-to-back without the macro: same stimulus → in_ready = 0 during STREAM; exactly one out_valid = 0 cycle between tiles.
- Reset mid-stream at w=3, N=4 → all outputs 0 next cycle; in_ready = 1; a new tile produces a correct stream from w=0.
- Width/extremes, N=3, DW=16: all elements 0xFFFF → padding positions exactly 0; no sign extension or overflow.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic activation skew feeder.
// The feeder turns an N x N tile into 2N-1 diagonal waves; the helpers below
// give the wave count and the width of the wave counter for a given N.
package systolic_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Number of diagonal waves emitted for one N x N tile.
   function automatic int wave_count(input int n);
      return 2 * n - 1;
   endfunction

   // Width of a counter that spans 0 .. 2N-2, never narrower than one bit.
   function automatic int wave_cnt_width(input int n);
      return (wave_count(n) < 2) ? 1 : $clog2(wave_count(n));
   endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// One output lane of the skew feeder. Lane L of wave w carries element
// A[L][w-L] of its tile row when that column exists, and zero otherwise,
// which produces the one-cycle-per-lane staircase the array expects.
module skew_lane_mux
   import systolic_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int L  = 0
) (
   input  logic [N*DW-1:0]              row,
   input  logic [wave_cnt_width(N)-1:0] wave,
   output logic [DW-1:0]                lane
);

   // Pick the column whose diagonal matches this wave; all other waves pad with zero.
   always_comb begin
      lane = '0;
      for (int c = 0; c < N; c++) begin
         if (int'(wave) == c + L) begin
            lane = row[c*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Activation skew feeder for an N x N systolic array.
// Accepts a row-major tile over valid/ready and emits 2N-1 diagonal waves,
// lane i delayed by i cycles and zero padded, with output back-pressure.
// Optional feature macro: SKEW_FEEDER_DBUF_EN adds a shadow tile buffer so a
// following tile can be streamed back-to-back without an idle cycle.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N*N*DW-1:0] in_tile,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N*DW-1:0]   out_data,
   output logic              out_first,
   output logic              out_last
);

   localparam int WAVES = wave_count(N);
   localparam int CW    = wave_cnt_width(N);
   localparam int TW    = N * N * DW;
   localparam logic [CW-1:0] LAST_W = CW'(WAVES - 1);

   state_t          state;
   state_t          next_state;
   logic [CW-1:0]   wave_cnt;
   logic [CW-1:0]   next_wave;
   logic [TW-1:0]   active_buf;
   logic [TW-1:0]   next_active;
   logic            in_fire;
   logic            out_fire;
   logic            last_fire;
   logic [N*DW-1:0] wave_data;
   logic            next_out_valid;
   logic [N*DW-1:0] next_out_data;
   logic            next_out_first;
   logic            next_out_last;
`ifdef SKEW_FEEDER_DBUF_EN
   logic [TW-1:0]   shadow_buf;
   logic [TW-1:0]   next_shadow;
   logic            shadow_full;
   logic            next_shadow_full;
`endif

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign last_fire = out_fire && (wave_cnt == LAST_W);

   // Wave lanes are computed from the next tile/counter so the output register
   // holds exactly what is presented this cycle and stays frozen on a stall.
   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_lane_mux #(
         .N  (N),
         .DW (DW),
         .L  (i)
      ) u_lane (
         .row  (next_active[i*N*DW +: N*DW]),
         .wave (next_wave),
         .lane (wave_data[i*DW +: DW])
      );
   end

   // State register: FSM, wave counter, tile buffers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         wave_cnt   <= '0;
         active_buf <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
`ifdef SKEW_FEEDER_DBUF_EN
         shadow_buf  <= '0;
         shadow_full <= 1'b0;
`endif
      end else begin
         state      <= next_state;
         wave_cnt   <= next_wave;
         active_buf <= next_active;
         out_valid  <= next_out_valid;
         out_data   <= next_out_data;
         out_first  <= next_out_first;
         out_last   <= next_out_last;
`ifdef SKEW_FEEDER_DBUF_EN
         shadow_buf  <= next_shadow;
         shadow_full <= next_shadow_full;
`endif
      end
   end

   // Next-state logic: tile capture, wave advance on consumption, tile hand-over.
   always_comb begin
      next_state  = state;
      next_wave   = wave_cnt;
      next_active = active_buf;
`ifdef SKEW_FEEDER_DBUF_EN
      next_shadow      = shadow_buf;
      next_shadow_full = shadow_full;
`endif
      case (state)
         IDLE: begin
            if (in_fire) begin
               next_active = in_tile;
               next_wave   = '0;
               next_state  = STREAM;
            end
         end
         STREAM: begin
            if (last_fire) begin
`ifdef SKEW_FEEDER_DBUF_EN
               if (shadow_full) begin
                  next_active      = shadow_buf;
                  next_shadow_full = 1'b0;
                  next_wave        = '0;
               end else if (in_fire) begin
                  next_active = in_tile;
                  next_wave   = '0;
               end else begin
                  next_state = IDLE;
                  next_wave  = '0;
               end
`else
               next_state = IDLE;
               next_wave  = '0;
`endif
            end else begin
               if (out_fire) begin
                  next_wave = wave_cnt + CW'(1);
               end
`ifdef SKEW_FEEDER_DBUF_EN
               if (in_fire) begin
                  next_shadow      = in_tile;
                  next_shadow_full = 1'b1;
               end
`endif
            end
         end
         default: begin
            next_state = IDLE;
            next_wave  = '0;
         end
      endcase
   end

   // Output logic: in_ready from state/buffer occupancy only, plus next output values.
   always_comb begin
      case (state)
         IDLE:    in_ready = 1'b1;
`ifdef SKEW_FEEDER_DBUF_EN
         STREAM:  in_ready = !shadow_full;
`else
         STREAM:  in_ready = 1'b0;
`endif
         default: in_ready = 1'b0;
      endcase
      next_out_valid = (next_state == STREAM);
      next_out_data  = next_out_valid ? wave_data : '0;
      next_out_first = next_out_valid && (next_wave == '0);
      next_out_last  = next_out_valid && (next_wave == LAST_W);
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder. Three instances cover N=2/DW=8,
// N=4/DW=8 and N=3/DW=16. Stimulus pushes hand-computed waves into per-DUT
// queues; monitors compare every presented wave against the queue head and
// pop it once the wave is consumed.
module tb_systolic_skew_feeder;

   typedef struct {
      logic [63:0] data;
      logic        first;
      logic        last;
   } wave_t;

`ifdef SKEW_FEEDER_DBUF_EN
   localparam int   EXP_GAP       = 0;
   localparam logic EXP_IR_STREAM = 1'b1;
`else
   localparam int   EXP_GAP       = 1;
   localparam logic EXP_IR_STREAM = 1'b0;
`endif

   localparam logic [31:0] EXP4 [7] = '{32'h00000011, 32'h00002112, 32'h00312213,
                                        32'h41322314, 32'h42332400, 32'h43340000,
                                        32'h44000000};
   localparam logic [47:0] EXP3 [5] = '{48'h0000_0000_FFFF, 48'h0000_FFFF_FFFF,
                                        48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_0000,
                                        48'hFFFF_0000_0000};

   logic clk = 1'b0;
   logic reset;

   logic         v2, ir2, ov2, r2, f2, l2;
   logic [31:0]  t2;
   logic [15:0]  d2;
   logic         v4, ir4, ov4, r4, f4, l4;
   logic [127:0] t4;
   logic [31:0]  d4;
   logic         v3, ir3, ov3, r3, f3, l3;
   logic [143:0] t3;
   logic [47:0]  d3;

   wave_t q2[$];
   wave_t q4[$];
   wave_t q3[$];

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic seen_last2 = 1'b0;
   int   gap2       = 0;
   int   last_gap2  = -1;
   logic [127:0] tile4;

   systolic_skew_feeder #(.N(2), .DW(8)) u_dut2 (
      .clk(clk), .reset(reset), .in_valid(v2), .in_ready(ir2), .in_tile(t2),
      .out_valid(ov2), .out_ready(r2), .out_data(d2), .out_first(f2), .out_last(l2));

   systolic_skew_feeder #(.N(4), .DW(8)) u_dut4 (
      .clk(clk), .reset(reset), .in_valid(v4), .in_ready(ir4), .in_tile(t4),
      .out_valid(ov4), .out_ready(r4), .out_data(d4), .out_first(f4), .out_last(l4));

   systolic_skew_feeder #(.N(3), .DW(16)) u_dut3 (
      .clk(clk), .reset(reset), .in_valid(v3), .in_ready(ir3), .in_tile(t3),
      .out_valid(ov3), .out_ready(r3), .out_data(d3), .out_first(f3), .out_last(l3));

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic expectWave(input int sel, input logic [63:0] data,
                             input logic first, input logic last);
      wave_t w;
      w.data  = data;
      w.first = first;
      w.last  = last;
      case (sel)
         2:       q2.push_back(w);
         4:       q4.push_back(w);
         default: q3.push_back(w);
      endcase
   endtask

   function automatic logic readyOf(input int sel);
      case (sel)
         2:       return ir2;
         4:       return ir4;
         default: return ir3;
      endcase
   endfunction

   function automatic int qsize(input int sel);
      case (sel)
         2:       return q2.size();
         4:       return q4.size();
         default: return q3.size();
      endcase
   endfunction

   // Present a tile, wait (bounded) for the handshake edge, then drop valid.
   task automatic applyStimulus(input int sel, input logic [143:0] tile);
      int k = 0;
      case (sel)
         2:       begin t2 = tile[31:0];  v2 = 1'b1; end
         4:       begin t4 = tile[127:0]; v4 = 1'b1; end
         default: begin t3 = tile;        v3 = 1'b1; end
      endcase
      @(negedge clk);
      while (!readyOf(sel) && k < 50) begin
         @(negedge clk);
         k++;
      end
      checkOutput($sformatf("u%0d_handshake", sel), 64'(readyOf(sel)), 64'(1));
      @(posedge clk);
      #1;
      v2 = 1'b0;
      v4 = 1'b0;
      v3 = 1'b0;
   endtask

   task automatic waitDrain(input int sel);
      int k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (qsize(sel) != 0 && k < 200);
      checkOutput($sformatf("u%0d_drain", sel), 64'(qsize(sel)), 64'(0));
   endtask

   // Monitor for the N=2 instance; also measures idle cycles between tiles.
   always @(negedge clk) begin
      if (!reset) begin
         if (ov2) begin
            if (q2.size() == 0) begin
               checkOutput("u2_spurious_wave", 64'(d2), 64'hDEAD);
            end else begin
               checkOutput("u2_data", 64'(d2), q2[0].data);
               checkOutput("u2_first", 64'(f2), 64'(q2[0].first));
               checkOutput("u2_last", 64'(l2), 64'(q2[0].last));
               if (r2) void'(q2.pop_front());
            end
            if (f2 && seen_last2) last_gap2 <= gap2;
            if (l2 && r2) begin
               seen_last2 <= 1'b1;
               gap2       <= 0;
            end
         end else if (seen_last2) begin
            gap2 <= gap2 + 1;
         end
      end
   end

   // Monitor for the N=4 instance.
   always @(negedge clk) begin
      if (!reset && ov4) begin
         if (q4.size() == 0) begin
            checkOutput("u4_spurious_wave", 64'(d4), 64'hDEAD);
         end else begin
            checkOutput("u4_data", 64'(d4), q4[0].data);
            checkOutput("u4_first", 64'(f4), 64'(q4[0].first));
            checkOutput("u4_last", 64'(l4), 64'(q4[0].last));
            if (r4) void'(q4.pop_front());
         end
      end
   end

   // Monitor for the N=3 wide-data instance.
   always @(negedge clk) begin
      if (!reset && ov3) begin
         if (q3.size() == 0) begin
            checkOutput("u3_spurious_wave", 64'(d3), 64'hDEAD);
         end else begin
            checkOutput("u3_data", 64'(d3), q3[0].data);
            checkOutput("u3_first", 64'(f3), 64'(q3[0].first));
            checkOutput("u3_last", 64'(l3), 64'(q3[0].last));
            if (r3) void'(q3.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      v2 = 1'b0; v4 = 1'b0; v3 = 1'b0;
      r2 = 1'b1; r4 = 1'b1; r3 = 1'b1;
      t2 = '0;   t4 = '0;   t3 = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            tile4[(r*4+c)*8 +: 8] = 8'((r + 1) * 16 + (c + 1));

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_u2_valid", 64'(ov2), 64'(0));
      checkOutput("rst_u2_data", 64'(d2), 64'(0));
      checkOutput("rst_u2_in_ready", 64'(ir2), 64'(1));
      checkOutput("rst_u4_valid", 64'(ov4), 64'(0));
      checkOutput("rst_u4_first", 64'(f4), 64'(0));
      checkOutput("rst_u4_last", 64'(l4), 64'(0));
      checkOutput("rst_u3_data", 64'(d3), 64'(0));
      reset = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] basic N=2 tile [[1,2],[3,4]]");
      expectWave(2, 64'h0001, 1'b1, 1'b0);
      expectWave(2, 64'h0302, 1'b0, 1'b0);
      expectWave(2, 64'h0400, 1'b0, 1'b1);
      applyStimulus(2, 144'h04030201);
      waitDrain(2);
      checkOutput("u2_idle_valid", 64'(ov2), 64'(0));
      checkOutput("u2_idle_data", 64'(d2), 64'(0));
      checkOutput("u2_idle_in_ready", 64'(ir2), 64'(1));

      $display("[TB] back-pressure N=4, 3 stall cycles at w=2");
      for (int w = 0; w < 7; w++) expectWave(4, 64'(EXP4[w]), w == 0, w == 6);
      applyStimulus(4, 144'(tile4));
      @(posedge clk); #1;
      @(posedge clk); #1;
      r4 = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("u4_stall_data", 64'(d4), 64'(EXP4[2]));
      r4 = 1'b1;
      waitDrain(4);
      checkOutput("u4_idle_valid", 64'(ov4), 64'(0));

      $display("[TB] back-to-back N=2");
      expectWave(2, 64'h0001, 1'b1, 1'b0);
      expectWave(2, 64'h0302, 1'b0, 1'b0);
      expectWave(2, 64'h0400, 1'b0, 1'b1);
      expectWave(2, 64'h0005, 1'b1, 1'b0);
      expectWave(2, 64'h0706, 1'b0, 1'b0);
      expectWave(2, 64'h0800, 1'b0, 1'b1);
      applyStimulus(2, 144'h04030201);
      @(posedge clk);
      #1;
      checkOutput("u2_in_ready_stream", 64'(ir2), 64'(EXP_IR_STREAM));
      applyStimulus(2, 144'h08070605);
      waitDrain(2);
      checkOutput("u2_b2b_gap", 64'(last_gap2), 64'(EXP_GAP));

      $display("[TB] reset mid-stream N=4 at w=3");
      for (int w = 0; w < 7; w++) expectWave(4, 64'(EXP4[w]), w == 0, w == 6);
      applyStimulus(4, 144'(tile4));
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      q4.delete();
      #2;
      checkOutput("u4_rst_valid", 64'(ov4), 64'(0));
      checkOutput("u4_rst_data", 64'(d4), 64'(0));
      checkOutput("u4_rst_first", 64'(f4), 64'(0));
      checkOutput("u4_rst_last", 64'(l4), 64'(0));
      checkOutput("u4_rst_in_ready", 64'(ir4), 64'(1));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("u4_post_rst_valid", 64'(ov4), 64'(0));
      checkOutput("u4_post_rst_in_ready", 64'(ir4), 64'(1));
      for (int w = 0; w < 7; w++) expectWave(4, 64'(EXP4[w]), w == 0, w == 6);
      applyStimulus(4, 144'(tile4));
      waitDrain(4);

      $display("[TB] extremes N=3 DW=16 all 0xFFFF");
      for (int w = 0; w < 5; w++) expectWave(3, 64'(EXP3[w]), w == 0, w == 4);
      applyStimulus(3, {144{1'b1}});
      waitDrain(3);
      checkOutput("u3_idle_valid", 64'(ov3), 64'(0));
      checkOutput("u3_idle_data", 64'(d3), 64'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
